bwd_input_pipe: RTL and testbench
=================================

BWD_INPUT_PIPE -- requirements
Module: bwd_input_pipe

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 1536, the width of the payload bundle (k/l, cnt, cntl, ik, p_x, and the backward fields, concatenated).
REQ-002 The block SHALL expose parameter DEPTH, default 1, the number of register stages; the legal range is 1..4.
REQ-003 The block SHALL expose parameter BUBBLE, default 6'b110000, the status code that marks an empty slot.
REQ-004 clk  input  1  Clock; all state updates on the rising edge.
REQ-005 rst  input  1  Reset, synchronous, active-low.
REQ-006 stall  input  1  Global stall; when 1, all state holds.
REQ-007 flush  input  1  When 1, invalidates all stages.
REQ-008 all_done_in  input  1  Upstream forward-all-done level.
REQ-009 in_status  input  6  Status of the incoming token.
REQ-010 in_payload  input  DATA_W  Payload of the incoming token.
REQ-011 out_status  output  6  Status at the last stage.
REQ-012 out_payload  output  DATA_W  Payload at the last stage.
REQ-013 occ  output  3  Count of stages whose status is not BUBBLE.
REQ-014 fsm_state  output  2  Drain FSM state: RUN=0, DRAIN=1, DONE=2.
REQ-015 all_done_out  output  1  Pipeline drained after all_done_in.
REQ-016 tok_cnt  output  32  Count of valid tokens that have left the pipe.

Function
REQ-017 Each stage s (0..DEPTH-1) SHALL hold a 6-bit status register and a DATA_W-bit payload register; stage 0 loads from the in_* ports, and stage s loads from stage s-1.
REQ-018 On a clock edge with rst=1 and stall=0 and flush=0, all stages SHALL shift by one.
REQ-019 A token SHALL appear on out_* exactly DEPTH non-stalled edges after it is sampled.
REQ-020 On an edge with stall=1, all stage registers, the FSM and tok_cnt SHALL hold their values, and flush and all_done_in SHALL be ignored on that edge.
REQ-021 On an edge with stall=0 and flush=1, every stage status SHALL be set to BUBBLE and every payload to 0; in_* is discarded on that edge.
REQ-022 When stall and flush are both 1, stall SHALL take priority and nothing changes; upstream holds flush until the first non-stalled edge.
REQ-023 out_status and out_payload SHALL be driven directly from the last-stage registers, with no combinational path from the inputs.
REQ-024 occ SHALL be the combinational count of stages whose status is not BUBBLE, in the range 0..DEPTH.
REQ-025 FSM transition RUN->DRAIN SHALL occur on a non-stalled edge with all_done_in=1.
REQ-026 FSM transition DRAIN->DONE SHALL occur on a non-stalled edge with occ=0.
REQ-027 The DONE state SHALL be absorbing until reset.
REQ-028 all_done_out SHALL be 1 if and only if fsm_state equals DONE.
REQ-029 A flush in the DRAIN state SHALL empty the pipe, and DONE SHALL follow on the next non-stalled edge.
REQ-030 If all_done_in=1 and occ=0 in the RUN state, the FSM SHALL pass through DRAIN for exactly one non-stalled edge before reaching DONE.

Reset
REQ-031 When rst=0 on an edge, all stage statuses SHALL be set to BUBBLE, all payloads to 0, fsm_state to RUN and tok_cnt to 0, regardless of stall.
REQ-032 Consequently, after reset out_status=BUBBLE, out_payload=0, occ=0, all_done_out=0 and tok_cnt=0.
REQ-033 Reset asserted mid-operation, including in the DRAIN or DONE state, SHALL discard all tokens in flight with no residual output.

Configuration
REQ-034 With macro BWD_PIPE_STATS_EN defined, tok_cnt SHALL increment on each non-stalled edge where the last-stage status is not BUBBLE and flush=0.
REQ-035 With BWD_PIPE_STATS_EN defined, tok_cnt SHALL saturate at 32'hFFFFFFFF.
REQ-036 Without BWD_PIPE_STATS_EN, tok_cnt SHALL be tied to 0 and no counter logic SHALL be instantiated.

Verification
REQ-037 Latency: DEPTH=3, inject status=5 with payload=0xA5 at cycle 0, then bubbles -> out_status=5 and out_payload=0xA5 at cycle 3 only; occ=1 during cycles 1..3.
REQ-038 Stall: DEPTH=2, a token is in stage 0, stall held for 4 cycles -> outputs and occ are frozen; the token exits 2 non-stalled edges after stall drops.
REQ-039 Flush vs stall: DEPTH=4 full of status=5 tokens, flush=1 with stall=1 -> no change (occ=4); stall then drops -> occ=0 and out_status=6'b110000.
REQ-040 Drain: DEPTH=2 with two valid tokens in flight, all_done_in=1 -> state goes DRAIN, then occ reaches 0, then DONE, with all_done_out=1 on the edge after occ becomes 0.
REQ-041 Reset mid-DRAIN: rst=0 for one cycle -> fsm_state=RUN, occ=0, tok_cnt=0.
REQ-042 Stats: with BWD_PIPE_STATS_EN, pass 10 valid tokens and 5 bubbles -> tok_cnt=10; without the macro -> tok_cnt=0.

Source files
------------

// File: rtl/bwd_input_pipe.sv
// bwd_input_pipe: DEPTH-stage register pipe carrying backward-pass input tokens
// (6-bit status + DATA_W payload). Empty slots carry the BUBBLE status code.
// A small drain FSM (RUN -> DRAIN -> DONE) reports when the pipe has emptied
// after upstream signalled forward-all-done.
// Optional feature: define BWD_PIPE_STATS_EN to build the saturating tok_cnt
// counter of valid tokens leaving the pipe; otherwise tok_cnt is tied to zero.
module bwd_input_pipe #(
    parameter int          DATA_W = 1536,
    parameter int          DEPTH  = 1,
    parameter logic [5:0]  BUBBLE = 6'b110000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              all_done_in,
    input  logic [5:0]        in_status,
    input  logic [DATA_W-1:0] in_payload,
    output logic [5:0]        out_status,
    output logic [DATA_W-1:0] out_payload,
    output logic [2:0]        occ,
    output logic [1:0]        fsm_state,
    output logic              all_done_out,
    output logic [31:0]       tok_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    logic [5:0]        status_q  [DEPTH];
    logic [5:0]        status_d  [DEPTH];
    logic [DATA_W-1:0] payload_q [DEPTH];
    logic [DATA_W-1:0] payload_d [DEPTH];
    logic [2:0]        occ_s;
    state_e            state_q;
    logic              all_done_q;

    // Stage next-state: stall holds, flush empties, otherwise shift by one.
    always_comb begin
        for (int s = 0; s < DEPTH; s++) begin
            status_d[s]  = status_q[s];
            payload_d[s] = payload_q[s];
        end
        if (stall) begin
            for (int s = 0; s < DEPTH; s++) begin
                status_d[s]  = status_q[s];
                payload_d[s] = payload_q[s];
            end
        end else if (flush) begin
            for (int s = 0; s < DEPTH; s++) begin
                status_d[s]  = BUBBLE;
                payload_d[s] = {DATA_W{1'b0}};
            end
        end else begin
            status_d[0]  = in_status;
            payload_d[0] = in_payload;
            for (int s = 1; s < DEPTH; s++) begin
                status_d[s]  = status_q[s-1];
                payload_d[s] = payload_q[s-1];
            end
        end
    end

    // Stage registers; reset wins over stall so no token survives a reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < DEPTH; s++) begin
                status_q[s]  <= BUBBLE;
                payload_q[s] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int s = 0; s < DEPTH; s++) begin
                status_q[s]  <= status_d[s];
                payload_q[s] <= payload_d[s];
            end
        end
    end

    // Occupancy: number of stages currently holding a non-bubble status.
    always_comb begin
        occ_s = 3'd0;
        for (int s = 0; s < DEPTH; s++) begin
            if (status_q[s] != BUBBLE) begin
                occ_s = occ_s + 3'd1;
            end else begin
                occ_s = occ_s;
            end
        end
    end

    // Drain FSM with registered done flag; DONE is left only through reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            all_done_q <= 1'b0;
        end else if (!stall) begin
            case (state_q)
                ST_RUN: begin
                    if (all_done_in) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        state_q <= ST_RUN;
                    end
                    all_done_q <= 1'b0;
                end
                ST_DRAIN: begin
                    if (occ_s == 3'd0) begin
                        state_q    <= ST_DONE;
                        all_done_q <= 1'b1;
                    end else begin
                        state_q    <= ST_DRAIN;
                        all_done_q <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_q    <= ST_DONE;
                    all_done_q <= 1'b1;
                end
                default: begin
                    state_q    <= ST_RUN;
                    all_done_q <= 1'b0;
                end
            endcase
        end else begin
            state_q    <= state_q;
            all_done_q <= all_done_q;
        end
    end

`ifdef BWD_PIPE_STATS_EN
    logic [31:0] tok_cnt_q;

    // Saturating count of valid tokens leaving the last stage (flushed ones excluded).
    always_ff @(posedge clk) begin
        if (!rst) begin
            tok_cnt_q <= 32'd0;
        end else if (!stall && !flush && (status_q[DEPTH-1] != BUBBLE)
                     && (tok_cnt_q != 32'hFFFF_FFFF)) begin
            tok_cnt_q <= tok_cnt_q + 32'd1;
        end else begin
            tok_cnt_q <= tok_cnt_q;
        end
    end

    assign tok_cnt = tok_cnt_q;
`else
    assign tok_cnt = 32'd0;
`endif

    assign out_status   = status_q[DEPTH-1];
    assign out_payload  = payload_q[DEPTH-1];
    assign occ          = occ_s;
    assign fsm_state    = state_q;
    assign all_done_out = all_done_q;

endmodule

// File: tb/tb_bwd_input_pipe.sv
// Bench for bwd_input_pipe: four instances (DEPTH 1..4) share one stimulus
// stream. The reference model is a single token history (newest first):
// a pipe of depth D shows history entry D-1 at its output, and its occupancy
// is the number of valid tokens among the newest D entries.
module tb_bwd_input_pipe;

    localparam int         DW  = 1536;
    localparam logic [5:0] BUB = 6'b110000;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic          flush;
    logic          all_done_in;
    logic [5:0]    in_status;
    logic [DW-1:0] in_payload;

    logic [5:0]    o_st   [4];
    logic [DW-1:0] o_pl   [4];
    logic [2:0]    o_occ  [4];
    logic [1:0]    o_fsm  [4];
    logic          o_done [4];
    logic [31:0]   o_cnt  [4];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        bwd_input_pipe #(.DATA_W(DW), .DEPTH(gi + 1), .BUBBLE(BUB)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .stall        (stall),
            .flush        (flush),
            .all_done_in  (all_done_in),
            .in_status    (in_status),
            .in_payload   (in_payload),
            .out_status   (o_st[gi]),
            .out_payload  (o_pl[gi]),
            .occ          (o_occ[gi]),
            .fsm_state    (o_fsm[gi]),
            .all_done_out (o_done[gi]),
            .tok_cnt      (o_cnt[gi])
        );
    end

    // Reference model state
    logic [5:0]    h_st [$];
    logic [DW-1:0] h_pl [$];
    int            m_fsm [4];
    logic [31:0]   m_cnt [4];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pl(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed[63:0]=%0h expected[63:0]=%0h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    function automatic logic [DW-1:0] rnd_pl();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int m_occ(input int d);
        int n = 0;
        for (int i = 0; i <= d; i++) if (h_st[i] != BUB) n++;
        return n;
    endfunction

    task automatic model_clear();
        h_st.delete();
        h_pl.delete();
        for (int i = 0; i < 4; i++) begin
            h_st.push_back(BUB);
            h_pl.push_back({DW{1'b0}});
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("out_status_d%0d", d + 1), 64'(o_st[d]), 64'(h_st[d]));
            chk_pl($sformatf("out_payload_d%0d", d + 1), o_pl[d], h_pl[d]);
            chk($sformatf("occ_d%0d", d + 1), 64'(o_occ[d]), 64'(m_occ(d)));
            chk($sformatf("fsm_d%0d", d + 1), 64'(o_fsm[d]), 64'(m_fsm[d]));
            chk($sformatf("all_done_d%0d", d + 1), 64'(o_done[d]), 64'(m_fsm[d] == 2));
            chk($sformatf("tok_cnt_d%0d", d + 1), 64'(o_cnt[d]), 64'(m_cnt[d]));
        end
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic step(input logic r, input logic s, input logic f, input logic a,
                        input logic [5:0] st, input logic [DW-1:0] pl);
        rst = r; stall = s; flush = f; all_done_in = a;
        in_status = st; in_payload = pl;
        if (!r) begin
            model_clear();
            for (int d = 0; d < 4; d++) begin
                m_fsm[d] = 0;
                m_cnt[d] = 32'd0;
            end
        end else if (!s) begin
            for (int d = 0; d < 4; d++) begin
                int oc;
                oc = m_occ(d);
                if (m_fsm[d] == 0 && a) m_fsm[d] = 1;
                else if (m_fsm[d] == 1 && oc == 0) m_fsm[d] = 2;
`ifdef BWD_PIPE_STATS_EN
                if (!f && h_st[d] != BUB && m_cnt[d] != 32'hFFFF_FFFF) m_cnt[d]++;
`endif
            end
            if (f) begin
                model_clear();
            end else begin
                h_st.push_front(st);
                h_pl.push_front(pl);
                void'(h_st.pop_back());
                void'(h_pl.pop_back());
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    function automatic logic [5:0] rnd_st();
        if ($urandom_range(0, 2) == 0) return BUB;
        return 6'($urandom_range(0, 63));
    endfunction

    initial begin
        logic [DW-1:0] pl_a5;
        logic          all_d;
        pl_a5 = {DW{1'b0}};
        pl_a5[7:0] = 8'hA5;
        model_clear();
        for (int d = 0; d < 4; d++) begin
            m_fsm[d] = 0;
            m_cnt[d] = 32'd0;
        end

        // Reset, including reset while stall/flush/all_done are high
        step(1'b0, 1'b0, 1'b0, 1'b0, BUB, {DW{1'b0}});
        step(1'b0, 1'b1, 1'b1, 1'b1, 6'd5, rnd_pl());

        // Latency: single token followed by bubbles
        step(1'b1, 1'b0, 1'b0, 1'b0, 6'd5, pl_a5);
        repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0, BUB, {DW{1'b0}});

        // Stall freezes a token in flight
        step(1'b1, 1'b0, 1'b0, 1'b0, 6'd7, rnd_pl());
        repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 6'd9, rnd_pl());
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, BUB, rnd_pl());

        // Flush versus stall on a full pipe
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 6'd5, rnd_pl());
        chk("occ_full_d4", 64'(o_occ[3]), 64'd4);
        repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0, 6'd3, rnd_pl());
        chk("occ_flush_stalled_d4", 64'(o_occ[3]), 64'd4);
        step(1'b1, 1'b0, 1'b1, 1'b0, 6'd3, rnd_pl());
        chk("occ_flushed_d4", 64'(o_occ[3]), 64'd0);
        chk("out_status_flushed_d4", 64'(o_st[3]), 64'(BUB));

        // Random traffic with stalls and flushes
        repeat (300) step(1'b1, ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0),
                          1'b0, rnd_st(), rnd_pl());

        // Drain with two tokens in flight, a flush while draining
        step(1'b1, 1'b0, 1'b0, 1'b0, 6'd1, rnd_pl());
        step(1'b1, 1'b0, 1'b0, 1'b0, 6'd2, rnd_pl());
        step(1'b1, 1'b0, 1'b0, 1'b1, BUB, rnd_pl());
        step(1'b1, 1'b0, 1'b1, 1'b0, 6'd4, rnd_pl());
        all_d = 1'b0;
        for (int k = 0; k < 30 && !all_d; k++) begin
            step(1'b1, ($urandom_range(0, 3) == 0), 1'b0, 1'b0, BUB, rnd_pl());
            all_d = o_done[0] & o_done[1] & o_done[2] & o_done[3];
        end
        for (int d = 0; d < 4; d++) chk($sformatf("drained_d%0d", d + 1), 64'(o_done[d]), 64'd1);

        // DONE is absorbing under further traffic
        repeat (20) step(1'b1, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                         1'($urandom_range(0, 1)), rnd_st(), rnd_pl());

        // Reset in the middle of DRAIN
        step(1'b0, 1'b0, 1'b0, 1'b0, BUB, {DW{1'b0}});
        step(1'b1, 1'b0, 1'b0, 1'b0, 6'd1, rnd_pl());
        step(1'b1, 1'b0, 1'b0, 1'b0, 6'd2, rnd_pl());
        step(1'b1, 1'b0, 1'b0, 1'b1, 6'd3, rnd_pl());
        chk("fsm_drain_d4", 64'(o_fsm[3]), 64'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 6'd3, rnd_pl());
        chk("fsm_after_rst_d4", 64'(o_fsm[3]), 64'd0);
        chk("occ_after_rst_d4", 64'(o_occ[3]), 64'd0);

        // Empty pipe: exactly one edge in DRAIN before DONE
        step(1'b1, 1'b0, 1'b0, 1'b1, BUB, rnd_pl());
        step(1'b1, 1'b1, 1'b0, 1'b1, BUB, rnd_pl());
        step(1'b1, 1'b0, 1'b0, 1'b0, BUB, rnd_pl());
        chk("fsm_done_empty_d3", 64'(o_fsm[2]), 64'd2);

        // Stats: 10 valid tokens interleaved with 5 bubbles, then let them leave
        step(1'b0, 1'b0, 1'b0, 1'b0, BUB, {DW{1'b0}});
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0,
                 (i % 3 == 2) ? BUB : 6'($urandom_range(0, 47)), rnd_pl());
        end
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, BUB, rnd_pl());
        for (int d = 0; d < 4; d++) begin
`ifdef BWD_PIPE_STATS_EN
            chk($sformatf("stats_total_d%0d", d + 1), 64'(o_cnt[d]), 64'd10);
`else
            chk($sformatf("stats_total_d%0d", d + 1), 64'(o_cnt[d]), 64'd0);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
